// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS datapath blocks
// (register file, ALU, decoder, writeback mux).
package mips_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int NUM_REGS       = 2 ** DEFAULT_ADDR_W;

  // Index of the hard-wired zero register $0.
  localparam logic [DEFAULT_ADDR_W-1:0] REG_ZERO = '0;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port of the register file.
// Selects an entry from the array and forces $0 to read as zero.
// Optional macro REG_FILE_BYPASS_EN adds write-through from the write
// port when it targets the same (non-zero) index in the same cycle.
module reg_file_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
`ifdef REG_FILE_BYPASS_EN
  input  logic [ADDR_W-1:0] a3,
  input  logic              we3,
  input  logic [DATA_W-1:0] wd3,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic addr_is_zero;

  assign addr_is_zero = (addr == ADDR_W'(REG_ZERO));

  // Array select, optional write-through, then $0 forcing (highest priority).
  always_comb begin
    // NOTE: assign a default before any conditional so no path leaves rdata
    // unassigned; otherwise synthesis infers a latch.
    rdata = regs[addr];
`ifdef REG_FILE_BYPASS_EN
    if (we3 && (a3 != ADDR_W'(REG_ZERO)) && (a3 == addr)) begin
      rdata = wd3;
    end
`endif
    if (addr_is_zero) begin
      rdata = '0;
    end
  end

endmodule : reg_file_read_port

// File: rtl/reg_file.sv
// reg_file: three-port MIPS architectural register file.
// Two combinational read ports (rd1/rd2), one write port clocked on the
// rising edge, $0 hard-wired to zero, whole array cleared on async reset.
// Optional macro REG_FILE_BYPASS_EN: same-cycle write-through to reads.
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic              we3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  // Writes to $0 are dropped here so the stored entry 0 stays zero.
  assign wr_en = we3 && (a3 != ADDR_W'(REG_ZERO));

  // Storage: asynchronous clear of every entry, otherwise single-port write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset on purpose: software relies on every
      // register reading zero after reset, so this cannot map to a plain
      // RAM macro; the for-loop unrolls into per-entry clears.
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment for sequential state so every flop
        // samples pre-edge values, independent of statement order.
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .regs  (regs),
    .addr  (a1),
`ifdef REG_FILE_BYPASS_EN
    .a3    (a3),
    .we3   (we3),
    .wd3   (wd3),
`endif
    .rdata (rd1)
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .regs  (regs),
    .addr  (a2),
`ifdef REG_FILE_BYPASS_EN
    .a3    (a3),
    .we3   (we3),
    .wd3   (wd3),
`endif
    .rdata (rd2)
  );

endmodule : reg_file
